serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 40 ++++
 rtl/serial_subtractor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//
//   Signals (WIDTH = operand width):
//     start   request, sampled only while the subtractor is idle
//     i0      minuend, captured on the accepted start edge
//     i1      subtrahend, captured on the accepted start edge
//     bin     borrow-in, captured on the accepted start edge
//     diff    registered difference
//     borrow  registered borrow-out
//     busy    high while an operation is in flight (SHIFT or DONE)
//     done    one-cycle completion pulse
//
//   Modports:
//     master  the controller / bench side that launches operations
//     slave   the subtractor itself
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output start, i0, i1, bin,
    input  diff, borrow, busy, done
  );

  modport slave (
    input  start, i0, i1, bin,
    output diff, borrow, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: computes i0 - i1 - bin LSB-first, one bit per
//   clock, through a single 1-bit full subtractor. Trades the area of a
//   parallel subtractor for WIDTH cycles of latency.
//
//   Result: {borrow, diff} = (i0 - i1 - bin) mod 2^(WIDTH+1).
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous, active-low reset
//     bus    serial_subtractor_if.slave (start/i0/i1/bin in,
//            diff/borrow/busy/done out)
//
//   Timing (start edge = edge 0): diff, borrow and done become valid after
//   edge WIDTH; busy is high from edge 0 until edge WIDTH+1. A start seen
//   while busy is dropped, not queued.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             borrow_q;
  logic [CW-1:0]    cnt;

  logic             bit_d;
  logic             br_nxt;
  logic             last_bit;

  // The 1-bit full subtractor operating on the current LSBs of the operand
  // shift registers and the stored borrow. A borrow is produced when the
  // subtrahend bit exceeds the minuend bit, or when they are equal and a
  // borrow is already pending.
  always_comb begin
    bit_d    = reg_a[0] ^ reg_b[0] ^ br;
    br_nxt   = (~reg_a[0] & reg_b[0]) | (~(reg_a[0] ^ reg_b[0]) & br);
    last_bit = (cnt == LAST_BIT);
  end

  // State register. Reset always returns to IDLE, abandoning any operation
  // in flight so no done pulse can escape afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. SHIFT runs for exactly WIDTH edges; DONE is a single
  // cycle so that done is a one-cycle pulse derived straight from state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands are captured only on an accepted start, so later
  // changes on i0/i1/bin cannot disturb an operation. The result builds up
  // in res by right-shifting each new bit into the MSB; after WIDTH shifts
  // bit 0 has reached position 0. The visible diff/borrow registers are
  // written only on the final bit, so they keep the previous result for the
  // whole of SHIFT. The final bit is merged in directly because res itself
  // has not yet been updated on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_a    <= '0;
      reg_b    <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            reg_a <= bus.i0;
            reg_b <= bus.i1;
            br    <= bus.bin;
            cnt   <= '0;
            res   <= '0;
          end
        end
        SHIFT: begin
          reg_a <= {1'b0, reg_a[WIDTH-1:1]};
          reg_b <= {1'b0, reg_b[WIDTH-1:1]};
          res   <= {bit_d, res[WIDTH-1:1]};
          br    <= br_nxt;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            diff_q   <= {bit_d, res[WIDTH-1:1]};
            borrow_q <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs decode directly from the registered state.
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule
